// File: rtl/mac_sched_pkg.sv
// Shared constants and types for the mac_sched multiply-add scheduler.
package mac_sched_pkg;

  localparam int W          = 8;
  localparam int MAC_LAT    = 3;
  localparam int INFLIGHT_W = $clog2(MAC_LAT + 1);

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;
  } mac_op_t;

  typedef logic [2*W-1:0] mac_res_t;

  function automatic logic [INFLIGHT_W-1:0] count3(input logic x, input logic y, input logic z);
    return INFLIGHT_W'({1'b0, x}) + INFLIGHT_W'({1'b0, y}) + INFLIGHT_W'({1'b0, z});
  endfunction

endpackage

// File: rtl/mac_sched_if.sv
// Requester/consumer bus of mac_sched: per-requester operand handshake plus the result stream.
interface mac_sched_if #(
  parameter int NREQ = 4
);
  import mac_sched_pkg::*;

  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ-1:0][W-1:0]  req_a;
  logic [NREQ-1:0][W-1:0]  req_b;
  logic [NREQ-1:0][W-1:0]  req_c;
  logic                    res_valid;
  logic                    res_ready;
  logic [IDW-1:0]          res_id;
  mac_res_t                res_data;
  logic [INFLIGHT_W-1:0]   inflight;

  modport master (
    output req_valid, req_a, req_b, req_c, res_ready,
    input  req_ready, res_valid, res_id, res_data, inflight
  );

  modport slave (
    input  req_valid, req_a, req_b, req_c, res_ready,
    output req_ready, res_valid, res_id, res_data, inflight
  );

endinterface

// File: rtl/mac_sched_rr_arbiter.sv
// mac_rr_arbiter: picks the first requesting index at or above ptr (modulo NREQ);
// a constant ptr of 0 turns it into a lowest-index-wins priority arbiter.
module mac_rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            stall,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx
);

  // Rotating search; the found flag keeps only the first hit so grant stays one-hot.
  always_comb begin
    int  cand;
    logic found;
    grant = '0;
    idx   = '0;
    cand  = 0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      cand = (int'(ptr) + k) % NREQ;
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = IDW'(cand);
      end
    end
    if (stall) begin
      grant = '0;
    end
  end

endmodule

// File: rtl/mac_sched.sv
// mac_sched: shares a 3-stage unsigned a*b+c pipeline between NREQ requesters.
// Define MAC_SCHED_FIXED_PRIO_EN for fixed (lowest index wins) arbitration instead of round-robin.
module mac_sched
  import mac_sched_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic       clk,
  input  logic       reset,
  mac_sched_if.slave bus
);

  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]       grant;
  logic [IDW-1:0]        gnt_idx;
  logic [IDW-1:0]        arb_ptr;
  logic                  stall;
  logic                  xfer;
  mac_op_t               op_sel;

  logic                  s1_valid;
  logic [IDW-1:0]        s1_id;
  mac_op_t               s1_op;
  logic                  s2_valid;
  logic [IDW-1:0]        s2_id;
  mac_res_t              s2_prod;
  logic [W-1:0]          s2_c;
  logic                  s3_valid;
  logic [IDW-1:0]        s3_id;
  mac_res_t              s3_res;
  logic [INFLIGHT_W-1:0] inflight;

  // A result waiting on the consumer freezes the whole pipeline, pointer included.
  assign stall = s3_valid && !bus.res_ready;
  assign xfer  = |grant;

  mac_rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .req   (bus.req_valid),
    .ptr   (arb_ptr),
    .stall (stall),
    .grant (grant),
    .idx   (gnt_idx)
  );

`ifdef MAC_SCHED_FIXED_PRIO_EN
  assign arb_ptr = '0;
`else
  logic [IDW-1:0] ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (xfer) begin
      ptr <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
    end
  end

  assign arb_ptr = ptr;
`endif

  always_comb begin
    op_sel   = '0;
    op_sel.a = bus.req_a[gnt_idx];
    op_sel.b = bus.req_b[gnt_idx];
    op_sel.c = bus.req_c[gnt_idx];
  end

  // Data registers load only behind a valid bit, so idle stages keep their last contents.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_id    <= '0;
      s1_op    <= '0;
      s2_valid <= 1'b0;
      s2_id    <= '0;
      s2_prod  <= '0;
      s2_c     <= '0;
      s3_valid <= 1'b0;
      s3_id    <= '0;
      s3_res   <= '0;
      inflight <= '0;
    end else if (!stall) begin
      s1_valid <= xfer;
      if (xfer) begin
        s1_id <= gnt_idx;
        s1_op <= op_sel;
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_id   <= s1_id;
        s2_prod <= mac_res_t'(s1_op.a) * mac_res_t'(s1_op.b);
        s2_c    <= s1_op.c;
      end
      s3_valid <= s2_valid;
      if (s2_valid) begin
        s3_id  <= s2_id;
        s3_res <= s2_prod + {{W{1'b0}}, s2_c};
      end
      inflight <= count3(xfer, s1_valid, s2_valid);
    end
  end

  assign bus.req_ready = grant;
  assign bus.res_valid = s3_valid;
  assign bus.res_id    = s3_id;
  assign bus.res_data  = s3_res;
  assign bus.inflight  = inflight;

endmodule

// File: tb/tb_mac_sched.sv
// Randomized self-checking bench for mac_sched against a cycle-level scoreboard model.
module tb_mac_sched;
  import mac_sched_pkg::*;

  localparam int NREQ = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  mac_sched_if #(.NREQ(NREQ)) bus ();

  mac_sched #(.NREQ(NREQ)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  bit pend [NREQ];
  int op_a [NREQ];
  int op_b [NREQ];
  int op_c [NREQ];

  // Model: arbitration pointer and the three result slots, oldest last.
  int m_ptr;
  bit m_v  [3];
  int m_id [3];
  int m_d  [3];

  task automatic checkOutput(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    m_ptr = 0;
    for (int i = 0; i < 3; i++) begin
      m_v[i]  = 1'b0;
      m_id[i] = 0;
      m_d[i]  = 0;
    end
    for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
  endtask

  function automatic int pickGrant(input logic [NREQ-1:0] v);
    int start;
`ifdef MAC_SCHED_FIXED_PRIO_EN
    start = 0;
`else
    start = m_ptr;
`endif
    for (int k = 0; k < NREQ; k++) begin
      if (v[(start + k) % NREQ]) return (start + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic loadOp(input int i, input int a, input int b, input int c);
    pend[i] = 1'b1;
    op_a[i] = a;
    op_b[i] = b;
    op_c[i] = c;
  endtask

  // One clock cycle: drive after the edge, check at the falling edge, advance the model.
  task automatic applyStimulus(input logic [NREQ-1:0] want, input logic rdy);
    logic [NREQ-1:0] v;
    int g;
    bit stall;
    for (int i = 0; i < NREQ; i++) begin
      if (!pend[i] && want[i]) begin
        loadOp(i, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
               int'($urandom_range(0, 255)));
      end
      v[i]          = pend[i];
      bus.req_a[i]  = W'(op_a[i]);
      bus.req_b[i]  = W'(op_b[i]);
      bus.req_c[i]  = W'(op_c[i]);
    end
    bus.req_valid = v;
    bus.res_ready = rdy;
    @(negedge clk);
    stall = m_v[2] && !rdy;
    g = stall ? -1 : pickGrant(v);
    checkOutput("req_ready", longint'(bus.req_ready), (g < 0) ? 0 : (longint'(1) << g));
    checkOutput("res_valid", longint'(bus.res_valid), longint'(m_v[2]));
    if (m_v[2]) begin
      checkOutput("res_id", longint'(bus.res_id), longint'(m_id[2]));
      checkOutput("res_data", longint'(bus.res_data), longint'(m_d[2]));
    end
    checkOutput("inflight", longint'(bus.inflight), longint'(int'(m_v[0]) + int'(m_v[1]) + int'(m_v[2])));
    if (!stall) begin
      for (int s = 2; s > 0; s--) begin
        m_v[s]  = m_v[s-1];
        m_id[s] = m_id[s-1];
        m_d[s]  = m_d[s-1];
      end
      m_v[0] = (g >= 0);
      if (g >= 0) begin
        m_id[0] = g;
        m_d[0]  = op_a[g] * op_b[g] + op_c[g];
        pend[g] = 1'b0;
        m_ptr   = (g + 1) % NREQ;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset         = 1'b1;
    bus.req_valid = '0;
    bus.res_ready = 1'b0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_c     = '0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_res_valid", longint'(bus.res_valid), 0);
    checkOutput("rst_res_id", longint'(bus.res_id), 0);
    checkOutput("rst_res_data", longint'(bus.res_data), 0);
    checkOutput("rst_inflight", longint'(bus.inflight), 0);
    checkOutput("rst_req_ready", longint'(bus.req_ready), 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] single op from requester 2");
    loadOp(2, 3, 4, 5);
    applyStimulus('0, 1'b1);
    applyStimulus('0, 1'b1);
    applyStimulus('0, 1'b1);
    checkOutput("single_valid", longint'(bus.res_valid), 1);
    checkOutput("single_id", longint'(bus.res_id), 2);
    checkOutput("single_data", longint'(bus.res_data), 17);
    repeat (3) applyStimulus('0, 1'b1);

    $display("[TB] maximum operands");
    loadOp(0, 255, 255, 255);
    applyStimulus('0, 1'b1);
    applyStimulus('0, 1'b1);
    applyStimulus('0, 1'b1);
    checkOutput("max_data", longint'(bus.res_data), 65280);
    repeat (3) applyStimulus('0, 1'b1);

    $display("[TB] all requesters continuously valid");
    repeat (10) applyStimulus(4'b1111, 1'b1);
    repeat (6) applyStimulus('0, 1'b1);

    $display("[TB] backpressure with three ops in flight");
    repeat (3) applyStimulus(4'b0111, 1'b1);
    repeat (4) applyStimulus(4'b1111, 1'b0);
    repeat (10) applyStimulus('0, 1'b1);

    $display("[TB] requesters 1 and 3 only");
    repeat (5) applyStimulus(4'b1010, 1'b1);
    repeat (3) applyStimulus(4'b1000, 1'b1);
    repeat (5) applyStimulus('0, 1'b1);

    $display("[TB] reset while the pipeline is full");
    repeat (3) applyStimulus(4'b1111, 1'b1);
    checkOutput("pre_reset_inflight", longint'(bus.inflight), 3);
    reset = 1'b1;
    #1;
    checkOutput("midrst_res_valid", longint'(bus.res_valid), 0);
    checkOutput("midrst_inflight", longint'(bus.inflight), 0);
    checkOutput("midrst_res_data", longint'(bus.res_data), 0);
    bus.req_valid = '0;
    modelReset();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    loadOp(1, 10, 20, 30);
    applyStimulus('0, 1'b1);
    applyStimulus('0, 1'b1);
    applyStimulus('0, 1'b1);
    checkOutput("postrst_id", longint'(bus.res_id), 1);
    checkOutput("postrst_data", longint'(bus.res_data), 230);
    repeat (3) applyStimulus('0, 1'b1);

    $display("[TB] random traffic");
    for (int n = 0; n < 400; n++) begin
      applyStimulus(NREQ'($urandom), ($urandom_range(0, 3) != 0));
    end
    repeat (12) applyStimulus('0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
    $finish;
  end

endmodule
